// File: rtl/pipe_pkg.sv
// Shared pipeline constants and helpers for the fetch buffer and its neighbours.
// popcnt_therm counts valid lanes and reports whether they form a lane-0-first thermometer.
package pipe_pkg;

  localparam int          IW       = 32;
  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam int          PC_STEP  = 4;
  localparam int          MAX_LANE = 4;

  typedef struct packed {
    logic [2:0] cnt;
    logic       therm;
  } therm_info_t;

  // A thermometer v satisfies v & (v+1) == 0 when the sum wraps inside MAX_LANE bits.
  function automatic therm_info_t popcnt_therm(input logic [MAX_LANE-1:0] v);
    therm_info_t         r;
    logic [MAX_LANE-1:0] inc;
    r.cnt = '0;
    for (int i = 0; i < MAX_LANE; i++) begin
      r.cnt = r.cnt + 3'(v[i]);
    end
    inc     = v + 1'b1;
    r.therm = ((v & inc) == '0);
    return r;
  endfunction

endpackage

// File: rtl/fetch_queue_ram.sv
// DEPTH-entry storage for the fetch queue: NLANE writes and NLANE combinational
// reads per cycle, each group at consecutive addresses that wrap modulo DEPTH.
module fetch_queue_ram #(
  parameter int NLANE = 2,
  parameter int DEPTH = 8,
  parameter int EW    = 64,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic [NLANE-1:0]    we,
  input  logic [PW-1:0]       waddr,
  input  logic [NLANE*EW-1:0] wdata,
  input  logic [PW-1:0]       raddr,
  output logic [NLANE*EW-1:0] rdata
);

  logic [EW-1:0] mem [DEPTH];

  // NOTE: storage carries no reset; occupancy is tracked by count, so stale entries are never observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NLANE; i++) begin
      if (we[i]) mem[waddr + PW'(i)] <= wdata[i*EW +: EW];
    end
  end

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NLANE; i++) begin
      rdata[i*EW +: EW] = mem[raddr + PW'(i)];
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch buffer between IF and ID/issue: NLANE-wide pushes, partial
// issue from the oldest end, one-cycle flush on branch/jump redirect.
module fetch_queue #(
  parameter int NLANE = 2,
  parameter int DEPTH = 8,
  parameter int IW    = pipe_pkg::IW,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int TW   = $clog2(NLANE + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic [NLANE-1:0]    in_valid,
  input  logic [NLANE*IW-1:0] in_inst,
  input  logic [31:0]         in_pc,
  output logic                in_ready,
  output logic [NLANE-1:0]    out_valid,
  output logic [NLANE*IW-1:0] out_inst,
  output logic [NLANE*32-1:0] out_pc,
  input  logic [TW-1:0]       out_take,
  output logic [CW-1:0]       count,
  output logic                err
);
  import pipe_pkg::NOP;
  import pipe_pkg::PC_STEP;
  import pipe_pkg::MAX_LANE;
  import pipe_pkg::therm_info_t;
  import pipe_pkg::popcnt_therm;

  localparam int EW = IW + 32;

  logic [PW-1:0]       head, tail;
  therm_info_t         vinfo;
  logic                push_en, take_over, err_set;
  logic [CW-1:0]       push_k, take, take_req;
  logic [NLANE-1:0]    we;
  logic [NLANE*EW-1:0] wdata, rdata;

  assign in_ready  = (count <= CW'(DEPTH - NLANE));
  assign vinfo     = popcnt_therm(MAX_LANE'(in_valid));
  assign push_en   = in_ready & in_valid[0] & ~flush;
  assign push_k    = push_en ? CW'(vinfo.cnt) : '0;
  assign take_req  = CW'(out_take);
  assign take_over = (take_req > count);
  assign take      = take_over ? count : take_req;
  assign err_set   = (in_ready & ~vinfo.therm) | (take_over & ~flush);

  // Only the first push_k lanes are written, so a malformed valid mask cannot leave holes.
  always_comb begin
    we    = '0;
    wdata = '0;
    for (int i = 0; i < NLANE; i++) begin
      we[i]             = push_en & (CW'(i) < push_k);
      wdata[i*EW +: EW] = {in_pc + 32'(PC_STEP * i), in_inst[i*IW +: IW]};
    end
  end

  fetch_queue_ram #(
    .NLANE (NLANE),
    .DEPTH (DEPTH),
    .EW    (EW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (tail),
    .wdata (wdata),
    .raddr (head),
    .rdata (rdata)
  );

  always_comb begin
    out_valid = '0;
    out_inst  = '0;
    out_pc    = '0;
    for (int i = 0; i < NLANE; i++) begin
      out_valid[i] = (count > CW'(i));
      if (out_valid[i]) begin
        out_inst[i*IW +: IW] = rdata[i*EW +: IW];
        out_pc[i*32 +: 32]   = rdata[i*EW + IW +: 32];
      end else begin
        out_inst[i*IW +: IW] = IW'(NOP);
        out_pc[i*32 +: 32]   = 32'h0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(take);
      tail  <= tail + PW'(push_k);
      count <= count + push_k - take;
    end
  end

  // err survives flush; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset)        err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction fetch buffer between the IF stage and the ID/issue stage of the multi-issue MIPS pipeline.
- Generalises the fixed two-instruction IF/ID register to NLANE lanes with a DEPTH-entry circular queue.
- Fetch can run ahead of issue, and a partial issue leaves the younger instructions queued.
- Branch/jump flush discards all buffered instructions in one cycle.

Parameters:
- NLANE, 2, instructions delivered per fetch and maximum issued per cycle (1..4).
- DEPTH, 8, queue entries; power of two, DEPTH >= 2*NLANE.
- IW, 32, instruction width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all contents (pcsrc | jump); synchronous.
- in_valid  in  NLANE  fetch lane valid; must be thermometer (lane 0 first).
- in_inst  in  NLANE*IW  fetched instructions, lane i at bits [i*IW +: IW].
- in_pc  in  32  PC of lane 0; lane i PC = in_pc + 4*i.
- in_ready  out  1  queue can accept a full NLANE group this cycle.
- out_valid  out  NLANE  thermometer; out_valid[i] = (count > i).
- out_inst  out  NLANE*IW  oldest NLANE entries, oldest in lane 0.
- out_pc  out  NLANE*32  PCs matching out_inst.
- out_take  in  $clog2(NLANE+1)  number of oldest entries consumed this cycle.
- count  out  $clog2(DEPTH+1)  current occupancy.
- err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (sync): head=0, tail=0, count=0, err=0. Outputs: out_valid=0, in_ready=1. Storage contents are don't-care. Reset overrides flush and all traffic.
- in_ready = (DEPTH - count >= NLANE). It is computed from registered count only, with no dependence on out_take.
- Push: when in_ready & in_valid[0] & !flush, write popcount(in_valid) entries at tail..tail+k-1 mod DEPTH, then tail += k. Push while !in_ready is ignored, never partially accepted.
- Pop: take = min(out_take, count). Then head += take mod DEPTH. Lanes not taken remain; the next cycle they appear in lane 0 onward.
- count_next = count + push_k - take. Simultaneous push and pop are legal. Full and empty are distinguished by count, not by pointer equality.
- Latency: an entry pushed in cycle N is first visible on out_* in cycle N+1. There is no input-to-output bypass.
- out_inst/out_pc are combinational reads at head+i. Lanes with out_valid[i]=0 drive IW'h0 (NOP) and pc 0.
- Flush: next cycle head=tail=count=0, out_valid=0. Same-cycle push and out_take are ignored. Flush does not clear err.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. A group may straddle the DEPTH-1/0 boundary.
- err is set (sticky until reset) when either condition holds:
  - in_valid is not a thermometer code while in_ready;
  - out_take > count while !flush.
- On an err condition the operation still proceeds with clipped take and popcount push.
- No state machine beyond the pointers and counter. All state is head, tail, count and err plus the storage array.

Decomposition:
- Shared package pipe_pkg:
  - IW;
  - NOP = 32'h0000_0000;
  - PC_STEP = 4;
  - a function popcnt_therm (popcount plus thermometer check).
- One natural sub-module: fetch_queue_ram. It is a DEPTH x (IW+32) register array with NLANE write ports at consecutive addresses and NLANE combinational read ports at consecutive addresses, with modulo addressing internal to it.
- Pointer, count and err logic remain in fetch_queue.

Test Plan:
- Fill: reset, then push 4 groups of {in_valid=2'b11, pc 0x00,0x08,0x10,0x18} with out_take=0 -> count 2,4,6,8; in_ready drops to 0 when count=8. A 5th push is ignored and count stays 8.
- Partial issue: queue holds pc 0x00..0x0C, out_take=1 -> next cycle out_pc lane0=0x04, lane1=0x08, count=3.
- Wrap: with head=6, push a group at tail=7 -> entries land in slots 7 and 0. Pop order pc matches push order across the boundary, and count returns to 0.
- Simultaneous: count=4, push 2, take 2 in the same cycle -> count stays 4, and the oldest output is the third-oldest entry from the prior cycle.
- Flush: count=6, flush=1 with a concurrent push and take=2 -> next cycle count=0, out_valid=0, in_ready=1, err unchanged.
- Protocol errors:
  - in_valid=2'b10 while in_ready -> err=1 next cycle; err holds through a flush and clears only on reset.
  - out_take=2 while count=1 -> only 1 is popped and err=1.
